seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, clk cycles per digit slot, legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port value  input  16  four hex digits, digit0 = value[3:0] (rightmost), digit3 = value[15:12].
REQ-005 SHALL have port dp_in  input  4  decimal-point request per digit, bit n = digit n.
REQ-006 SHALL have port load  input  1  one-cycle strobe, captures value and dp_in.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled live.
REQ-008 SHALL have port nibble  output  4  hex code of the active digit, feeds the seven-segment decoder.
REQ-009 SHALL have port dig_en_n  output  4  active-low digit enable, at most one bit low.
REQ-010 SHALL have port dp  output  1  decimal point for the active digit, active-high.
REQ-011 SHALL have port blank  output  1  1 = decoder must force all segments off this slot.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on the last cycle of each slot.
REQ-013 SHALL have port pending  output  1  1 = loaded value not yet shown.

Function
REQ-014 SHALL run a prescaler counting 0..CLK_DIV-1, wrapping to 0, tick=1 exactly when count = CLK_DIV-1.
REQ-015 SHALL hold a 2-bit digit index, incremented on the edge where tick=1, wrapping 3->0.
REQ-016 SHALL drive dig_en_n low on bit [index] only, else 4'b1111 when the slot is blanked.
REQ-017 SHALL drive nibble/dp from the display register slice selected by index, combinationally from registers, no extra latency.
REQ-018 SHALL write value/dp_in to a pending register on load and set pending=1, latest load winning.
REQ-019 SHALL transfer pending to display only on the tick edge where index goes 3->0 (frame boundary), then clear pending, so no frame shows mixed values.
REQ-020 SHALL, for a load on that same transfer edge: display takes the old pending contents, the new load stays pending (pending=1), shown next frame.
REQ-021 SHALL, with pending=0 at a frame boundary, leave display unchanged.
REQ-022 SHALL blank when blank_lz=1: digit3 if display[15:12]==0, digit2 if display[15:8]==0, digit1 if display[15:4]==0; never digit0.
REQ-023 SHALL force blank=1, dig_en_n=4'b1111, dp=0 in a blanked slot, nibble still driven.
REQ-024 SHALL size prescaler width as clog2(CLK_DIV), no overflow at CLK_DIV-1.

Reset
REQ-025 SHALL on rst=1 clear prescaler, index, display, display dp bits, pending register and pending flag, overriding load.
REQ-026 SHALL give reset output values nibble=0, dig_en_n=4'b1110, dp=0, blank=0, tick=0, pending=0.
REQ-027 SHALL resume scanning from digit0, count 0, on the first cycle after rst deasserts.

Structure
REQ-028 SHALL take NUM_DIGITS=4, DIGIT_W=4 and the active-low one-hot enable table from shared package disp_pkg.
REQ-029 SHALL place the prescaler/tick generator in sub-module scan_prescaler, parameterized by CLK_DIV.

Verification (CLK_DIV=4)
REQ-030 SHALL check reset then idle: dig_en_n cycles 1110,1101,1011,0111 with 4 cycles each, tick every 4th cycle, nibble=0.
REQ-031 SHALL check load 16'h1234 mid-frame: pending=1 and display 0 until the 3->0 wrap, then slots show 4,3,2,1 and pending=0.
REQ-032 SHALL check blank_lz=1, value 16'h0042: digits 3,2 blank=1, dig_en_n=1111; digit1=4, digit0=2; for value 0 only digit0 lit, showing 0.
REQ-033 SHALL check loads 16'h1111 then 16'h2222 in the same frame: next frame shows 2222 only.
REQ-034 SHALL check load 16'hABCD on the transfer edge with 16'h5555 pending: 5555 shown, pending stays 1, ABCD shown the following frame.
REQ-035 SHALL check rst pulse mid-frame with a load on the same cycle: next cycle all REQ-026 values, pending=0, load discarded.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display constants for the multiplexed seven-segment scanner:
// digit geometry, the active-low digit-enable table and leading-zero blanking.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

    localparam logic [NUM_DIGITS-1:0] DIG_EN_N_TBL [NUM_DIGITS] =
        '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_N = 4'b1111;

    // Bit n set means digit n is a leading zero to suppress; digit0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_blank(
        input logic [VALUE_W-1:0] v,
        input logic               en
    );
        logic [NUM_DIGITS-1:0] lz;
        lz = 4'b0000;
        if (en) begin
            lz[3] = (v[15:12] == 4'h0);
            lz[2] = (v[15:8]  == 8'h00);
            lz[1] = (v[15:4]  == 12'h000);
            lz[0] = 1'b0;
        end else begin
            lz = 4'b0000;
        end
        return lz;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-length prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each slot.
module scan_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic             last_s;

    // Decode the terminal count.
    always_comb begin
        last_s = (count_r == CNT_LAST);
    end

    // Free-running slot counter, wrapping at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (last_s) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign tick = last_s;

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display scanner with frame-aligned value updates
// and optional leading-zero blanking.
module seven_seg_scanner
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [DIGIT_W-1:0]    nibble,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  dp,
    output logic                  blank,
    output logic                  tick,
    output logic                  pending
);

    logic                  tick_s;
    logic                  frame_end_s;
    logic [IDX_W-1:0]      idx_r;
    logic [VALUE_W-1:0]    disp_val_r;
    logic [NUM_DIGITS-1:0] disp_dp_r;
    logic [VALUE_W-1:0]    pend_val_r;
    logic [NUM_DIGITS-1:0] pend_dp_r;
    logic                  pending_r;
    logic [NUM_DIGITS-1:0] lz_blank_s;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // The last tick of digit3 closes a frame; only then may the display change.
    always_comb begin
        frame_end_s = tick_s && (idx_r == 2'd3);
    end

    // Active digit index, advanced once per slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 2'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Pending capture and frame-boundary transfer; a load on the transfer edge
    // stays pending because the display takes the pre-edge pending contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val_r <= 16'h0000;
            disp_dp_r  <= 4'b0000;
            pend_val_r <= 16'h0000;
            pend_dp_r  <= 4'b0000;
            pending_r  <= 1'b0;
        end else begin
            if (frame_end_s && pending_r) begin
                disp_val_r <= pend_val_r;
                disp_dp_r  <= pend_dp_r;
            end else begin
                disp_val_r <= disp_val_r;
                disp_dp_r  <= disp_dp_r;
            end
            if (load) begin
                pend_val_r <= value;
                pend_dp_r  <= dp_in;
                pending_r  <= 1'b1;
            end else if (frame_end_s) begin
                pending_r  <= 1'b0;
            end else begin
                pending_r  <= pending_r;
            end
        end
    end

    // Leading-zero map of the shown value; blank_lz is applied live.
    always_comb begin
        lz_blank_s = lead_zero_blank(disp_val_r, blank_lz);
    end

    // Select the active digit straight from the display register.
    always_comb begin
        nibble   = 4'h0;
        dig_en_n = DIG_OFF_N;
        dp       = 1'b0;
        blank    = lz_blank_s[idx_r];
        case (idx_r)
            2'd0:    nibble = disp_val_r[3:0];
            2'd1:    nibble = disp_val_r[7:4];
            2'd2:    nibble = disp_val_r[11:8];
            2'd3:    nibble = disp_val_r[15:12];
            default: nibble = 4'h0;
        endcase
        if (blank) begin
            dig_en_n = DIG_OFF_N;
            dp       = 1'b0;
        end else begin
            dig_en_n = DIG_EN_N_TBL[idx_r];
            dp       = disp_dp_r[idx_r];
        end
    end

    assign tick    = tick_s;
    assign pending = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at CLK_DIV=4 (16-cycle frames).
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  dig_en_n;
    logic        dp;
    logic        blank;
    logic        tick;
    logic        pending;

    seven_seg_scanner #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .nibble   (nibble),
        .dig_en_n (dig_en_n),
        .dp       (dp),
        .blank    (blank),
        .tick     (tick),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        blz;
        logic [15:0] exp_nib;   // slot s at [4s+:4]
        logic [15:0] exp_en;    // slot s at [4s+:4]
        logic [3:0]  exp_blank; // bit s = slot s
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t        tbl [7];
    logic [3:0]  en_tbl [4];
    int          checks;
    int          errors;
    int          cyc;
    logic [15:0] prev_val;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_until(input int m);
        while (cyc % 16 != m) next_cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        next_cycle();
        load  = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_nibble",  {12'h000, nibble},   16'h0000);
        chk("rst_dig_en",  {12'h000, dig_en_n}, 16'h000E);
        chk("rst_dp",      {15'h0, dp},         16'h0000);
        chk("rst_blank",   {15'h0, blank},      16'h0000);
        chk("rst_tick",    {15'h0, tick},       16'h0000);
        chk("rst_pending", {15'h0, pending},    16'h0000);
    endtask

    // Called at a frame start; checks every slot's digit and the pending flag.
    task automatic chk_frame(input string tag, input logic [15:0] exp_val, input logic exp_pend);
        for (int s = 0; s < 4; s++) begin
            chk({tag, "_nibble"},  {12'h000, nibble}, {12'h000, exp_val[4*s +: 4]});
            chk({tag, "_pending"}, {15'h0, pending},  {15'h0, exp_pend});
            repeat (4) next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 16'h7BDE, 4'b0000, 4'b0000};
        tbl[1] = '{16'h0042, 4'b0000, 1'b1, 16'h0042, 16'hFFDE, 4'b1100, 4'b0000};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 16'hFFFE, 4'b1110, 4'b0000};
        tbl[3] = '{16'h0042, 4'b1111, 1'b1, 16'h0042, 16'hFFDE, 4'b1100, 4'b0011};
        tbl[4] = '{16'h0042, 4'b0101, 1'b0, 16'h0042, 16'h7BDE, 4'b0000, 4'b0101};
        tbl[5] = '{16'h0F00, 4'b0000, 1'b1, 16'h0F00, 16'hFBDE, 4'b1000, 4'b0000};
        tbl[6] = '{16'hA0B0, 4'b1000, 1'b1, 16'hA0B0, 16'h7BDE, 4'b0000, 4'b1000};
        en_tbl[0] = 4'b1110;
        en_tbl[1] = 4'b1101;
        en_tbl[2] = 4'b1011;
        en_tbl[3] = 4'b0111;

        checks   = 0;
        errors   = 0;
        cyc      = 0;
        prev_val = 16'h0000;
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        chk_reset_state();

        // Idle scan: one frame of enables, ticks and zero nibbles.
        for (int k = 0; k < 16; k++) begin
            chk("idle_dig_en", {12'h000, dig_en_n}, {12'h000, en_tbl[k / 4]});
            chk("idle_tick",   {15'h0, tick},       {15'h0, (k % 4 == 3)});
            chk("idle_nibble", {12'h000, nibble},   16'h0000);
            next_cycle();
        end

        // Table: mid-frame load, hold until the wrap, then check every slot.
        for (int r = 0; r < 7; r++) begin
            blank_lz = tbl[r].blz;
            wait_until(5);
            do_load(tbl[r].value, tbl[r].dp_in);
            chk("tbl_pending_set", {15'h0, pending}, 16'h0001);
            wait_until(15);
            chk("tbl_pending_hold", {15'h0, pending}, 16'h0001);
            chk("tbl_old_nibble", {12'h000, nibble}, {12'h000, prev_val[15:12]});
            next_cycle();
            chk("tbl_pending_clr", {15'h0, pending}, 16'h0000);
            for (int s = 0; s < 4; s++) begin
                chk("tbl_nibble", {12'h000, nibble},   {12'h000, tbl[r].exp_nib[4*s +: 4]});
                chk("tbl_dig_en", {12'h000, dig_en_n}, {12'h000, tbl[r].exp_en[4*s +: 4]});
                chk("tbl_blank",  {15'h0, blank},      {15'h0, tbl[r].exp_blank[s]});
                chk("tbl_dp",     {15'h0, dp},         {15'h0, tbl[r].exp_dp[s]});
                chk("tbl_tick0",  {15'h0, tick},       16'h0000);
                repeat (3) next_cycle();
                chk("tbl_tick1",  {15'h0, tick},       16'h0001);
                next_cycle();
            end
            prev_val = tbl[r].value;
        end

        // Two loads in one frame: only the later one is shown.
        blank_lz = 1'b0;
        wait_until(2);
        do_load(16'h1111, 4'b0000);
        wait_until(6);
        do_load(16'h2222, 4'b0000);
        wait_until(0);
        chk_frame("dbl", 16'h2222, 1'b0);

        // Load on the transfer edge: old pending shown, new stays pending.
        wait_until(4);
        do_load(16'h5555, 4'b0000);
        wait_until(15);
        value = 16'hABCD;
        load  = 1'b1;
        next_cycle();
        load  = 1'b0;
        chk_frame("edge_old", 16'h5555, 1'b1);
        chk_frame("edge_new", 16'hABCD, 1'b0);
        chk_frame("edge_hold", 16'hABCD, 1'b0);

        // Reset mid-frame with a simultaneous load: load is discarded.
        wait_until(6);
        rst      = 1'b1;
        load     = 1'b1;
        value    = 16'h9999;
        dp_in    = 4'b1111;
        next_cycle();
        rst  = 1'b0;
        load = 1'b0;
        cyc  = 0;
        chk_reset_state();
        repeat (16) next_cycle();
        chk("post_rst_pending", {15'h0, pending},    16'h0000);
        chk("post_rst_nibble",  {12'h000, nibble},   16'h0000);
        chk("post_rst_dp",      {15'h0, dp},         16'h0000);
        chk("post_rst_dig_en",  {12'h000, dig_en_n}, 16'h000E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
